sram_uart_responder: RTL and testbench
======================================

Name: sram_uart_responder

Overview:
- Target-side responder for the physical address and one-hot select produced by the address-mapping stage.
- Accepts a single-outstanding REQ/ACK transaction and executes it on BASE_RAM, EXT_RAM or the UART register pair.
- For SRAM targets it sequences the asynchronous SRAM control pins.
- For UART targets it drives the UART core's TX/RX strobes and returns status/data words.

Parameters:
ACCESS_CYCLES, 2, cycles CE_N plus OE_N/WE_N stay asserted per SRAM access; legal range 1..15.

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
REQ  input  1  transaction request, sampled only in IDLE
WE  input  1  1 = write, 0 = read
BE  input  4  byte enables for writes, active high
PADDR  input  20  SRAM word address (SRAM_ADDR_BUS)
SRAM_SEL  input  3  {uart, ext, base} one-hot select
UART_REG  input  1  UART register index: 0 = data, 1 = status
WDATA  input  32  write data
ACK  output  1  one-cycle completion pulse
RDATA  output  32  read data, valid while ACK = 1
BASE_RAM_ADDR  output  20  base SRAM address
BASE_RAM_DATA  inout  32  base SRAM data
BASE_RAM_BE_N  output  4  base SRAM byte enables, active low
BASE_RAM_CE_N  output  1  base SRAM chip enable, active low
BASE_RAM_OE_N  output  1  base SRAM output enable, active low
BASE_RAM_WE_N  output  1  base SRAM write enable, active low
EXT_RAM_*  same set of seven signals as BASE_RAM_*, for the ext SRAM
UART_TX_START  output  1  one-cycle TX start pulse
UART_TX_DATA  output  8  TX byte
UART_TX_BUSY  input  1  UART transmitter busy
UART_RX_READY  input  1  UART receive byte available
UART_RX_DATA  input  8  UART receive byte
UART_RX_CLEAR  output  1  one-cycle pulse consuming the RX byte

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-transaction):
  - State = IDLE; ACK = 0; RDATA = 0.
  - All *_CE_N/*_OE_N/*_WE_N = 1; *_BE_N = 4'hF; *_ADDR = 0; data pins high-Z.
  - UART_TX_START = 0; UART_TX_DATA = 0; UART_RX_CLEAR = 0.
  - Any partially executed transaction is abandoned and no ACK is issued.
- States: IDLE, ACCESS, UART_WAIT, DONE.
- IDLE:
  - On an edge with REQ = 1, latch WE, BE, PADDR, SRAM_SEL, UART_REG and WDATA.
  - The master need only hold these fields valid at that edge.
  - SRAM_SEL = base or ext: go to ACCESS and load the cycle counter with ACCESS_CYCLES-1.
  - SRAM_SEL = uart, data-register write, UART_TX_BUSY = 1: go to UART_WAIT.
  - All other cases: go to DONE.
- ACCESS (SRAM, selected bank only):
  - CE_N = 0; ADDR = latched PADDR.
  - Read: OE_N = 0, BE_N = 0, data pins high-Z.
  - Write: WE_N = 0, BE_N = ~BE, data pins driven with WDATA.
  - Counter decrements each cycle; at count 0 go to DONE.
  - Read: the DATA pins are captured into RDATA on the edge leaving ACCESS.
  - The unselected bank stays fully idle, as in reset.
- UART_WAIT: hold until UART_TX_BUSY = 0, then go to DONE. There is no timeout.
- DONE:
  - ACK = 1 for exactly one cycle, then return to IDLE.
  - SRAM: CE_N/OE_N/WE_N return to 1 on entering DONE.
  - SRAM write: data and ADDR stay driven through DONE to provide hold time; released to high-Z in IDLE.
  - UART data write: UART_TX_START = 1 in DONE; UART_TX_DATA = WDATA[7:0], held until the next UART write.
  - UART data read: RDATA = {24'b0, UART_RX_DATA}; UART_RX_CLEAR = 1 in DONE.
  - UART status read: RDATA = {30'b0, UART_RX_READY, ~UART_TX_BUSY}, i.e. bit0 = TX ready, bit1 = RX available.
  - UART status write: no side effect.
  - SRAM_SEL not one-hot (including 0): ACK with RDATA = 0 and no pin activity.
- Latency from the accepting edge to ACK high:
  - SRAM: ACCESS_CYCLES + 1 cycles.
  - UART: 1 cycle, plus any UART_WAIT cycles.
- Handshake:
  - REQ is ignored outside IDLE.
  - The master deasserts REQ or presents the next request on the edge where ACK = 1.
  - A REQ still high in the IDLE cycle after DONE starts a new transaction (back-to-back is allowed).
- RDATA holds its last value after ACK. It is only meaningful while ACK = 1.

Decomposition:
- Shared package holds:
  - State enum.
  - UART_DATA_REG/UART_STATUS_REG indices.
  - Status bit positions TX_READY_BIT = 0 and RX_AVAIL_BIT = 1.
  - SEL index constants BASE_IDX = 0, EXT_IDX = 1, UART_IDX = 2.
- Reuse the existing SELECTED and SRAM_ADDR_BUS defines.
- One natural sub-module, sram_bank_if, instanced twice (base, ext):
  - Inputs: active, write phase, hold phase, address, byte enables, write data.
  - Drives one bank's pins and the tri-state data bus.
  - Returns the sampled data.

Test Plan:
- Reset asserted during ACCESS of a base write -> WE_N/CE_N go high the same cycle, data pins high-Z, no ACK.
- Base write PADDR=20'h00010, BE=4'b0011, WDATA=32'hDEADBEEF, ACCESS_CYCLES=2:
  - BASE_RAM_WE_N low 2 cycles, BE_N=4'b1100.
  - ACK on the 3rd cycle after acceptance; EXT pins untouched.
- Ext read PADDR=20'hFFFFF, SRAM model returns 32'h12345678 -> EXT_RAM_OE_N low 2 cycles, ACK with RDATA=32'h12345678.
- UART data write 8'h41 with TX_BUSY high 5 cycles -> ACK and single TX_START pulse in the first cycle after TX_BUSY falls, TX_DATA=8'h41.
- UART status read with RX_READY=1, TX_BUSY=0 -> RDATA=32'h3. Then data read with RX_DATA=8'h5A -> RDATA=32'h5A and a one-cycle RX_CLEAR.
- Back-to-back: REQ held high across a base read then SRAM_SEL=3'b000 -> second transaction accepted in the IDLE cycle after the first ACK, ACK with RDATA=0, no pin activity.

Source files
------------

// File: rtl/sram_uart_responder_pkg.sv
// Shared types and constants for the SRAM/UART target-side responder.
`ifndef SRAM_ADDR_BUS
`define SRAM_ADDR_BUS 19:0
`endif
`ifndef SELECTED
`define SELECTED 1'b1
`endif

package sram_uart_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_UART_WAIT,
    ST_DONE
  } state_e;

  // UART register index carried on UART_REG
  localparam logic UART_DATA_REG   = 1'b0;
  localparam logic UART_STATUS_REG = 1'b1;

  // Status word bit positions
  localparam int TX_READY_BIT = 0;
  localparam int RX_AVAIL_BIT = 1;

  // Positions inside the {uart, ext, base} select vector
  localparam int BASE_IDX = 0;
  localparam int EXT_IDX  = 1;
  localparam int UART_IDX = 2;

  function automatic logic sel_onehot(input logic [2:0] sel);
    return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
  endfunction

  // Word returned for a UART register read
  function automatic logic [31:0] uart_read_word(input logic       ureg,
                                                 input logic       rx_ready,
                                                 input logic       tx_busy,
                                                 input logic [7:0] rx_data);
    logic [31:0] w;
    w = '0;
    if (ureg == UART_STATUS_REG) begin
      w[TX_READY_BIT] = ~tx_busy;
      w[RX_AVAIL_BIT] = rx_ready;
    end else begin
      w[7:0] = rx_data;
    end
    return w;
  endfunction

endpackage

// File: rtl/sram_uart_responder_if.sv
// Request/acknowledge bus between the address-mapping stage and the responder.
interface sram_uart_responder_if;
  logic                  REQ;
  logic                  WE;
  logic [3:0]            BE;
  logic [`SRAM_ADDR_BUS] PADDR;
  logic [2:0]            SRAM_SEL;
  logic                  UART_REG;
  logic [31:0]           WDATA;
  logic                  ACK;
  logic [31:0]           RDATA;

  modport master (
    output REQ, WE, BE, PADDR, SRAM_SEL, UART_REG, WDATA,
    input  ACK, RDATA
  );

  modport slave (
    input  REQ, WE, BE, PADDR, SRAM_SEL, UART_REG, WDATA,
    output ACK, RDATA
  );
endinterface

// File: rtl/sram_uart_responder_sram_bank_if.sv
// Pin driver for one asynchronous SRAM bank. Purely combinational: the
// responder FSM supplies the phase (active access / write hold), this block
// turns it into active-low strobes and owns the bank's tri-state data bus.
module sram_bank_if (
  input  logic                  active_i,
  input  logic                  write_i,
  input  logic                  hold_i,
  input  logic [`SRAM_ADDR_BUS] addr_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic [`SRAM_ADDR_BUS] ram_addr_o,
  output logic [3:0]            ram_be_n_o,
  output logic                  ram_ce_n_o,
  output logic                  ram_oe_n_o,
  output logic                  ram_we_n_o,
  inout  wire  [31:0]           ram_data_io,
  output logic [31:0]           rdata_o
);

  logic drive_data;

  // Write data stays on the pins through the hold phase after WE_N rises
  assign drive_data  = (active_i & write_i) | hold_i;

  assign ram_ce_n_o  = ~active_i;
  assign ram_oe_n_o  = ~(active_i & ~write_i);
  assign ram_we_n_o  = ~(active_i & write_i);
  assign ram_be_n_o  = !active_i ? 4'hF : (write_i ? ~be_i : 4'h0);
  assign ram_addr_o  = (active_i | hold_i) ? addr_i : '0;
  assign ram_data_io = drive_data ? wdata_i : 32'hzzzz_zzzz;
  assign rdata_o     = ram_data_io;

endmodule

// File: rtl/sram_uart_responder.sv
// Single-outstanding responder executing mapped requests on BASE_RAM,
// EXT_RAM or the UART data/status register pair.
module sram_uart_responder
  import sram_uart_responder_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  sram_uart_responder_if.slave  bus,
  output logic [`SRAM_ADDR_BUS] BASE_RAM_ADDR,
  inout  wire  [31:0]           BASE_RAM_DATA,
  output logic [3:0]            BASE_RAM_BE_N,
  output logic                  BASE_RAM_CE_N,
  output logic                  BASE_RAM_OE_N,
  output logic                  BASE_RAM_WE_N,
  output logic [`SRAM_ADDR_BUS] EXT_RAM_ADDR,
  inout  wire  [31:0]           EXT_RAM_DATA,
  output logic [3:0]            EXT_RAM_BE_N,
  output logic                  EXT_RAM_CE_N,
  output logic                  EXT_RAM_OE_N,
  output logic                  EXT_RAM_WE_N,
  output logic                  UART_TX_START,
  output logic [7:0]            UART_TX_DATA,
  input  logic                  UART_TX_BUSY,
  input  logic                  UART_RX_READY,
  input  logic [7:0]            UART_RX_DATA,
  output logic                  UART_RX_CLEAR
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [7:0]            txd_q, txd_d;
  logic                  we_q, ureg_q;
  logic [2:0]            sel_q;
  logic [`SRAM_ADDR_BUS] addr_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  ack, tx_start, rx_clear;
  logic                  tgt_base, tgt_ext, tgt_uart, uart_data;
  logic                  base_act, ext_act, base_hold, ext_hold;
  logic [31:0]           base_rdata, ext_rdata;
  logic                  req_sram, req_uart_wait;

  // Target decode of the latched request; a non-one-hot select hits nothing
  assign tgt_base  = sel_onehot(sel_q) && (sel_q[BASE_IDX] == `SELECTED);
  assign tgt_ext   = sel_onehot(sel_q) && (sel_q[EXT_IDX]  == `SELECTED);
  assign tgt_uart  = sel_onehot(sel_q) && (sel_q[UART_IDX] == `SELECTED);
  assign uart_data = tgt_uart && (ureg_q == UART_DATA_REG);

  // Dispatch decode of the live request presented in IDLE
  assign req_sram      = sel_onehot(bus.SRAM_SEL) &&
                         ((bus.SRAM_SEL[BASE_IDX] == `SELECTED) ||
                          (bus.SRAM_SEL[EXT_IDX]  == `SELECTED));
  assign req_uart_wait = sel_onehot(bus.SRAM_SEL) &&
                         (bus.SRAM_SEL[UART_IDX] == `SELECTED) &&
                         bus.WE && (bus.UART_REG == UART_DATA_REG) && UART_TX_BUSY;

  assign base_act  = (state_q == ST_ACCESS) && tgt_base;
  assign ext_act   = (state_q == ST_ACCESS) && tgt_ext;
  assign base_hold = (state_q == ST_DONE) && tgt_base && we_q;
  assign ext_hold  = (state_q == ST_DONE) && tgt_ext && we_q;

  // State, access counter and registered outputs; reset abandons any transaction
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      txd_q   <= txd_d;
    end
  end

  // Control fields of an accepted request; these steer the pin decode
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q   <= 1'b0;
      sel_q  <= '0;
      ureg_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.REQ) begin
      we_q   <= bus.WE;
      sel_q  <= bus.SRAM_SEL;
      ureg_q <= bus.UART_REG;
    end
  end

  // Payload of an accepted request; only reaches pins once gated by the FSM
  always_ff @(posedge CLK) begin
    if (state_q == ST_IDLE && bus.REQ) begin
      addr_q  <= bus.PADDR;
      be_q    <= bus.BE;
      wdata_q <= bus.WDATA;
    end
  end

  // Next-state, read-data capture and UART strobes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    txd_d    = txd_q;
    ack      = 1'b0;
    tx_start = 1'b0;
    rx_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.REQ) begin
          if (req_sram) begin
            state_d = ST_ACCESS;
            cnt_d   = CNT_LOAD;
          end else if (req_uart_wait) begin
            state_d = ST_UART_WAIT;
          end else begin
            state_d = ST_DONE;
            if (!sel_onehot(bus.SRAM_SEL)) begin
              rdata_d = '0;
            end else if (!bus.WE) begin
              rdata_d = uart_read_word(bus.UART_REG, UART_RX_READY, UART_TX_BUSY, UART_RX_DATA);
            end else if (bus.UART_REG == UART_DATA_REG) begin
              txd_d = bus.WDATA[7:0];
            end
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = tgt_ext ? ext_rdata : base_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_UART_WAIT: begin
        if (!UART_TX_BUSY) begin
          state_d = ST_DONE;
          txd_d   = wdata_q[7:0];
        end
      end
      ST_DONE: begin
        ack      = 1'b1;
        tx_start = uart_data && we_q;
        rx_clear = uart_data && !we_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ACK       = ack;
  assign bus.RDATA     = rdata_q;
  assign UART_TX_START = tx_start;
  assign UART_TX_DATA  = txd_q;
  assign UART_RX_CLEAR = rx_clear;

  sram_bank_if u_base (
    .active_i    (base_act),
    .write_i     (we_q),
    .hold_i      (base_hold),
    .addr_i      (addr_q),
    .be_i        (be_q),
    .wdata_i     (wdata_q),
    .ram_addr_o  (BASE_RAM_ADDR),
    .ram_be_n_o  (BASE_RAM_BE_N),
    .ram_ce_n_o  (BASE_RAM_CE_N),
    .ram_oe_n_o  (BASE_RAM_OE_N),
    .ram_we_n_o  (BASE_RAM_WE_N),
    .ram_data_io (BASE_RAM_DATA),
    .rdata_o     (base_rdata)
  );

  sram_bank_if u_ext (
    .active_i    (ext_act),
    .write_i     (we_q),
    .hold_i      (ext_hold),
    .addr_i      (addr_q),
    .be_i        (be_q),
    .wdata_i     (wdata_q),
    .ram_addr_o  (EXT_RAM_ADDR),
    .ram_be_n_o  (EXT_RAM_BE_N),
    .ram_ce_n_o  (EXT_RAM_CE_N),
    .ram_oe_n_o  (EXT_RAM_OE_N),
    .ram_we_n_o  (EXT_RAM_WE_N),
    .ram_data_io (EXT_RAM_DATA),
    .rdata_o     (ext_rdata)
  );

endmodule

// File: tb/tb_sram_uart_responder.sv
// Testbench for sram_uart_responder: vector table, scoreboard and corner sequences.
module tb_sram_uart_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_uart_responder_if bus();

  logic [19:0] base_addr, ext_addr;
  logic [3:0]  base_be_n, ext_be_n;
  logic        base_ce_n, base_oe_n, base_we_n;
  logic        ext_ce_n, ext_oe_n, ext_we_n;
  wire  [31:0] base_data, ext_data;
  logic        tx_start, tx_busy, rx_ready, rx_clear;
  logic [7:0]  tx_data, rx_data;

  sram_uart_responder #(.ACCESS_CYCLES(2)) dut (
    .CLK(clk), .RST(rst), .bus(bus),
    .BASE_RAM_ADDR(base_addr), .BASE_RAM_DATA(base_data), .BASE_RAM_BE_N(base_be_n),
    .BASE_RAM_CE_N(base_ce_n), .BASE_RAM_OE_N(base_oe_n), .BASE_RAM_WE_N(base_we_n),
    .EXT_RAM_ADDR(ext_addr), .EXT_RAM_DATA(ext_data), .EXT_RAM_BE_N(ext_be_n),
    .EXT_RAM_CE_N(ext_ce_n), .EXT_RAM_OE_N(ext_oe_n), .EXT_RAM_WE_N(ext_we_n),
    .UART_TX_START(tx_start), .UART_TX_DATA(tx_data), .UART_TX_BUSY(tx_busy),
    .UART_RX_READY(rx_ready), .UART_RX_DATA(rx_data), .UART_RX_CLEAR(rx_clear)
  );

  // SRAM models: 16 words each (address bits [3:0]), reloaded with a pattern in reset
  logic [31:0] base_mem [16];
  logic [31:0] ext_mem  [16];
  assign base_data = (!base_ce_n && !base_oe_n) ? base_mem[base_addr[3:0]] : 32'hzzzz_zzzz;
  assign ext_data  = (!ext_ce_n  && !ext_oe_n)  ? ext_mem[ext_addr[3:0]]   : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        base_mem[i] <= 32'hA5A5_0000 | i;
        ext_mem[i]  <= (i == 15) ? 32'h1234_5678 : (32'h5A5A_0000 | i);
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!base_ce_n && !base_we_n && !base_be_n[b]) base_mem[base_addr[3:0]][8*b +: 8] <= base_data[8*b +: 8];
        if (!ext_ce_n  && !ext_we_n  && !ext_be_n[b])  ext_mem[ext_addr[3:0]][8*b +: 8]   <= ext_data[8*b +: 8];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_released(input string name, input logic [31:0] act, input logic [31:0] wval);
    checks++;
    if (act === wval) begin
      errors++;
      $display("FAIL %s: data pins still %h, required released", name, act);
    end
  endtask

  // Scoreboard: expected read data and ACK latency per accepted request
  typedef struct {
    logic [31:0] exp;
    bit          chk;
    int          lat;
    int          start;
  } sb_t;
  sb_t sb[$];

  task automatic sb_push(input logic [31:0] exp, input bit chkr, input int lat);
    sb_t e;
    e.exp = exp; e.chk = chkr; e.lat = lat; e.start = cyc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (bus.ACK) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb unexpected ACK: got 1 required 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("sb latency", cyc - e.start, e.lat);
        if (e.chk) chk("sb rdata", bus.RDATA, e.exp);
      end
    end
  end

  // Called at a negedge in IDLE; request is accepted on the following edge
  task automatic do_req(input logic we, input logic [3:0] be, input logic [19:0] pa,
                        input logic [2:0] sel, input logic ureg, input logic [31:0] wd,
                        input bit chkr, input logic [31:0] exp, input int lat);
    bus.REQ = 1'b1; bus.WE = we; bus.BE = be; bus.PADDR = pa;
    bus.SRAM_SEL = sel; bus.UART_REG = ureg; bus.WDATA = wd;
    sb_push(exp, chkr, lat);
  endtask

  task automatic wait_ack(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.REQ = 1'b0;
      if (bus.ACK) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: ACK got 0 required 1 within 40 cycles", name);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [19:0] pa;
    logic [2:0]  sel;
    logic        ureg;
    logic [31:0] wd;
    logic        busy;
    logic        rxr;
    logic [7:0]  rxd;
    bit          chkr;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vec [15];

  localparam logic [6:0] IDLE_CTRL = 7'b111_1111;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec[0]  = '{1'b0, 4'h0, 20'h00010, 3'b001, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 1'b1, 32'hA5A5_BEEF, 3};
    vec[1]  = '{1'b1, 4'h9, 20'h00003, 3'b010, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0,         3};
    vec[2]  = '{1'b0, 4'h0, 20'h00003, 3'b010, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 1'b1, 32'hCA5A_000D, 3};
    vec[3]  = '{1'b0, 4'h0, 20'h00003, 3'b001, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 1'b1, 32'hA5A5_0003, 3};
    vec[4]  = '{1'b1, 4'hF, 20'h00005, 3'b001, 1'b0, 32'h0102_0304, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0,         3};
    vec[5]  = '{1'b0, 4'h0, 20'h00005, 3'b001, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 1'b1, 32'h0102_0304, 3};
    vec[6]  = '{1'b0, 4'h0, 20'h00000, 3'b100, 1'b1, 32'h0,         1'b0, 1'b1, 8'h00, 1'b1, 32'h3,         1};
    vec[7]  = '{1'b0, 4'h0, 20'h00000, 3'b100, 1'b1, 32'h0,         1'b1, 1'b0, 8'h00, 1'b1, 32'h0,         1};
    vec[8]  = '{1'b0, 4'h0, 20'h00000, 3'b100, 1'b1, 32'h0,         1'b1, 1'b1, 8'h00, 1'b1, 32'h2,         1};
    vec[9]  = '{1'b0, 4'h0, 20'h00000, 3'b100, 1'b0, 32'h0,         1'b0, 1'b1, 8'hC3, 1'b1, 32'hC3,        1};
    vec[10] = '{1'b1, 4'hF, 20'h00000, 3'b100, 1'b0, 32'h0000_0077, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0,         1};
    vec[11] = '{1'b1, 4'hF, 20'h00000, 3'b100, 1'b1, 32'h0000_0099, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0,         1};
    vec[12] = '{1'b0, 4'h0, 20'h00010, 3'b000, 1'b0, 32'h0,         1'b0, 1'b1, 8'h11, 1'b1, 32'h0,         1};
    vec[13] = '{1'b0, 4'h0, 20'h00010, 3'b011, 1'b0, 32'h0,         1'b0, 1'b1, 8'h11, 1'b1, 32'h0,         1};
    vec[14] = '{1'b1, 4'hF, 20'h00010, 3'b110, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 1'b0, 32'h0,         1};

    rst = 1'b1;
    bus.REQ = 1'b0; bus.WE = 1'b0; bus.BE = 4'h0; bus.PADDR = '0;
    bus.SRAM_SEL = 3'b000; bus.UART_REG = 1'b0; bus.WDATA = '0;
    tx_busy = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset ACK", 32'(bus.ACK), 32'h0);
    chk("reset RDATA", bus.RDATA, 32'h0);
    chk("reset base ctrl", 32'({base_ce_n, base_oe_n, base_we_n, base_be_n}), 32'(IDLE_CTRL));
    chk("reset ext ctrl", 32'({ext_ce_n, ext_oe_n, ext_we_n, ext_be_n}), 32'(IDLE_CTRL));
    chk("reset addr", 32'({base_addr, 4'h0}) | 32'(ext_addr), 32'h0);
    chk("reset uart", 32'({tx_start, tx_data, rx_clear}), 32'h0);
    rst = 1'b0;

    // Base write with partial byte enables
    @(negedge clk);
    do_req(1'b1, 4'b0011, 20'h00010, 3'b001, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 3);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      bus.REQ = 1'b0;
      chk("bwr ctrl", 32'({base_ce_n, base_oe_n, base_we_n, base_be_n}), 32'(7'b010_1100));
      chk("bwr addr/data", {12'h0, base_addr} ^ base_data, 32'h00010 ^ 32'hDEAD_BEEF);
      chk("bwr ext idle", 32'({ext_ce_n, ext_oe_n, ext_we_n, ext_be_n, ext_addr}), {5'h0, IDLE_CTRL, 20'h0});
      chk("bwr no ack", 32'(bus.ACK), 32'h0);
    end
    @(negedge clk);
    chk("bwr ack", 32'(bus.ACK), 32'h1);
    chk("bwr done strobes", 32'({base_ce_n, base_oe_n, base_we_n}), 32'h7);
    chk("bwr hold data", base_data, 32'hDEAD_BEEF);
    chk("bwr hold addr", 32'(base_addr), 32'h00010);
    @(negedge clk);
    chk_released("bwr idle data", base_data, 32'hDEAD_BEEF);
    chk("bwr idle addr", 32'(base_addr), 32'h0);

    // Ext read at the top of the address space
    do_req(1'b0, 4'h0, 20'hFFFFF, 3'b010, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 3);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      bus.REQ = 1'b0;
      chk("erd ctrl", 32'({ext_ce_n, ext_oe_n, ext_we_n, ext_be_n}), 32'(7'b001_0000));
      chk("erd addr", 32'(ext_addr), 32'hFFFFF);
      chk("erd base idle", 32'({base_ce_n, base_oe_n, base_we_n}), 32'h7);
    end
    @(negedge clk);
    chk("erd ack", 32'(bus.ACK), 32'h1);
    chk("erd done ctrl", 32'({ext_ce_n, ext_oe_n}), 32'h3);

    // Vector table
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      tx_busy = vec[k].busy; rx_ready = vec[k].rxr; rx_data = vec[k].rxd;
      do_req(vec[k].we, vec[k].be, vec[k].pa, vec[k].sel, vec[k].ureg, vec[k].wd,
             vec[k].chkr, vec[k].exp, vec[k].lat);
      wait_ack($sformatf("vec%0d", k));
    end
    chk("txdata after status write", 32'(tx_data), 32'h77);

    // UART data write stalled by a busy transmitter
    @(negedge clk);
    tx_busy = 1'b1;
    do_req(1'b1, 4'hF, 20'h0, 3'b100, 1'b0, 32'h0000_0041, 1'b0, 32'h0, 6);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.REQ = 1'b0;
      chk("utx wait no ack", 32'({bus.ACK, tx_start}), 32'h0);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    chk("utx ack+start", 32'({bus.ACK, tx_start}), 32'h3);
    chk("utx data", 32'(tx_data), 32'h41);
    @(negedge clk);
    chk("utx start pulse", 32'({bus.ACK, tx_start}), 32'h0);
    chk("utx data held", 32'(tx_data), 32'h41);

    // Status read then data read with RX_CLEAR pulse
    rx_ready = 1'b1; rx_data = 8'h5A;
    do_req(1'b0, 4'h0, 20'h0, 3'b100, 1'b1, 32'h0, 1'b1, 32'h3, 1);
    @(negedge clk);
    bus.REQ = 1'b0;
    chk("ust ack no clear", 32'({bus.ACK, rx_clear}), 32'h2);
    @(negedge clk);
    do_req(1'b0, 4'h0, 20'h0, 3'b100, 1'b0, 32'h0, 1'b1, 32'h5A, 1);
    @(negedge clk);
    bus.REQ = 1'b0;
    chk("urx ack+clear", 32'({bus.ACK, rx_clear}), 32'h3);
    @(negedge clk);
    chk("urx clear pulse", 32'({bus.ACK, rx_clear}), 32'h0);

    // Back-to-back: REQ held high from a base read into a null-select request
    do_req(1'b0, 4'h0, 20'h00010, 3'b001, 1'b0, 32'h0, 1'b1, 32'hA5A5_BEEF, 3);
    repeat (3) @(negedge clk);
    chk("b2b first ack", 32'(bus.ACK), 32'h1);
    bus.SRAM_SEL = 3'b000; bus.PADDR = 20'h00007;
    @(negedge clk);
    chk("b2b idle gap", 32'({bus.ACK, base_ce_n, ext_ce_n}), 32'h3);
    sb_push(32'h0, 1'b1, 1);
    @(negedge clk);
    bus.REQ = 1'b0;
    chk("b2b second ack", 32'(bus.ACK), 32'h1);
    chk("b2b no pins", 32'({base_ce_n, base_oe_n, base_we_n, ext_ce_n, ext_oe_n, ext_we_n, tx_start, rx_clear}), 32'hFC);
    chk("b2b addr idle", 32'(base_addr) | 32'(ext_addr), 32'h0);
    @(negedge clk);

    // Reset asserted in the middle of a base write
    do_req(1'b1, 4'hF, 20'h00002, 3'b001, 1'b0, 32'h55AA_55AA, 1'b0, 32'h0, 3);
    @(negedge clk);
    bus.REQ = 1'b0;
    chk("rst pre we_n", 32'({base_ce_n, base_we_n}), 32'h0);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rst strobes high", 32'({base_ce_n, base_oe_n, base_we_n, base_be_n}), 32'(IDLE_CTRL));
    chk("rst ack low", 32'(bus.ACK), 32'h0);
    chk_released("rst data released", base_data, 32'h55AA_55AA);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post-rst no ack", 32'(bus.ACK), 32'h0);
    end

    chk("sb drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
